// File: rtl/alu_seq.sv
// Chip-8 style 8XYN ALU with a valid/ready handshake and a multi-cycle binary-to-BCD
// extension (opcode 8) built on iterative shift-add-3.
module alu_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      op1,
    input  logic [WIDTH-1:0]      op2,
    input  logic [3:0]            opcode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  carry,
    output logic                  alu_err
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    function automatic longint unsigned pow10(input int n);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

    if (WIDTH < 4 || WIDTH > 32) begin : g_width_check
        $error("alu_seq: WIDTH=%0d outside 4..32", WIDTH);
    end
    if (pow10(DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_digits_check
        $error("alu_seq: DIGITS=%0d too small for WIDTH=%0d", DIGITS, WIDTH);
    end

    typedef enum logic [1:0] {
        IDLE,
        BCD_RUN,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            accept;
    logic [CW-1:0]   cnt;
    logic [WIDTH-1:0] bin_sh;
    logic [BW-1:0]   bcd_acc;
    logic [WIDTH-1:0] bin_step;
    logic [BW-1:0]   bcd_step;
    logic [WIDTH-1:0] out_r;
    logic [BW-1:0]   bcd_r;
    logic            carry_r;
    logic            err_r;
    logic [WIDTH-1:0] alu_out;
    logic            alu_carry;
    logic            alu_bad;

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign out       = out_r;
    assign bcd       = bcd_r;
    assign carry     = carry_r;
    assign alu_err   = err_r;

    // Digits that reach 5 or more get +3 so the following doubling carries into the next decade.
    function automatic logic [BW-1:0] add3(input logic [BW-1:0] digits);
        logic [BW-1:0] adj;
        adj = digits;
        for (int d = 0; d < DIGITS; d++) begin
            if (adj[4*d +: 4] >= 4'd5) adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
        end
        return adj;
    endfunction

    assign {bcd_step, bin_step} = {add3(bcd_acc), bin_sh} << 1;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
        alu_out   = '0;
        alu_carry = 1'b0;
        alu_bad   = 1'b0;
        case (opcode)
            4'h0: alu_out = op2;
            4'h1: alu_out = op1 | op2;
            4'h2: alu_out = op1 & op2;
            4'h3: alu_out = op1 ^ op2;
            4'h4: {alu_carry, alu_out} = {1'b0, op1} + {1'b0, op2};
            4'h5: begin
                alu_out   = op1 - op2;
                alu_carry = (op1 >= op2);
            end
            4'h6: begin
                alu_out   = op1 >> 1;
                alu_carry = op1[0];
            end
            4'h7: begin
                alu_out   = op2 - op1;
                alu_carry = (op2 >= op1);
            end
            4'h8: alu_out = op1;
            4'hE: begin
                alu_out   = op1 << 1;
                alu_carry = op1[WIDTH-1];
            end
            default: alu_bad = 1'b1;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (accept)
                    state_next = (opcode == 4'h8) ? BCD_RUN : DONE;
                else if (state == DONE && out_ready)
                    state_next = IDLE;
            end
            BCD_RUN: if (cnt == CNT_LAST) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_r   <= '0;
            bcd_r   <= '0;
            carry_r <= 1'b0;
            err_r   <= 1'b0;
            cnt     <= '0;
            bin_sh  <= '0;
            bcd_acc <= '0;
        end else if (accept) begin
            out_r   <= alu_out;
            bcd_r   <= '0;
            carry_r <= alu_carry;
            err_r   <= alu_bad;
            cnt     <= '0;
            bin_sh  <= op1;
            bcd_acc <= '0;
        end else if (state == BCD_RUN) begin
            bin_sh  <= bin_step;
            bcd_acc <= bcd_step;
            if (cnt == CNT_LAST) begin
                cnt   <= '0;
                bcd_r <= bcd_step;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed vector table, handshake/reset sequences,
// and randomized operations checked against a decimal-arithmetic reference model.
module tb_alu_seq;

    localparam int WIDTH  = 8;
    localparam int DIGITS = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  op1;
    logic [7:0]  op2;
    logic [3:0]  opcode;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out;
    logic [11:0] bcd;
    logic        carry;
    logic        alu_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op1(op1), .op2(op2), .opcode(opcode), .out_valid(out_valid),
        .out_ready(out_ready), .out(out), .bcd(bcd), .carry(carry), .alu_err(alu_err)
    );

    typedef struct {
        logic [7:0]  out;
        logic        carry;
        logic        err;
        logic [11:0] bcd;
    } result_t;

    typedef struct {
        string      name;
        logic [3:0] opc;
        logic [7:0] a;
        logic [7:0] b;
        result_t    exp;
    } vec_t;

    function automatic result_t model(input logic [3:0] opc, input int unsigned a, input int unsigned b);
        result_t r;
        r = '{out: 8'h00, carry: 1'b0, err: 1'b0, bcd: 12'h000};
        case (opc)
            4'h0: r.out = 8'(b);
            4'h1: r.out = 8'(a | b);
            4'h2: r.out = 8'(a & b);
            4'h3: r.out = 8'(a ^ b);
            4'h4: begin r.out = 8'((a + b) % 256); r.carry = (a + b) > 255; end
            4'h5: begin r.out = 8'((a + 256 - b) % 256); r.carry = (a >= b); end
            4'h6: begin r.out = 8'(a / 2); r.carry = (a % 2) == 1; end
            4'h7: begin r.out = 8'((b + 256 - a) % 256); r.carry = (b >= a); end
            4'h8: begin
                r.out = 8'(a);
                r.bcd = {4'((a / 100) % 10), 4'((a / 10) % 10), 4'(a % 10)};
            end
            4'hE: begin r.out = 8'((a * 2) % 256); r.carry = (a >= 128); end
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_result(input string name, input result_t exp);
        check({name, ".out_valid"}, 32'(out_valid), 32'd1);
        check({name, ".out"},       32'(out),       32'(exp.out));
        check({name, ".carry"},     32'(carry),     32'(exp.carry));
        check({name, ".alu_err"},   32'(alu_err),   32'(exp.err));
        check({name, ".bcd"},       32'(bcd),       32'(exp.bcd));
    endtask

    task automatic check_zero(input string name);
        check({name, ".out_valid"}, 32'(out_valid), 32'd0);
        check({name, ".out"},       32'(out),       32'd0);
        check({name, ".bcd"},       32'(bcd),       32'd0);
        check({name, ".carry"},     32'(carry),     32'd0);
        check({name, ".alu_err"},   32'(alu_err),   32'd0);
        check({name, ".in_ready"},  32'(in_ready),  32'd1);
    endtask

    // Called at a falling edge; returns at the falling edge where out_valid is first seen.
    task automatic send(input string name, input logic [3:0] opc, input logic [7:0] a, input logic [7:0] b);
        int lat;
        opcode   = opc;
        op1      = a;
        op2      = b;
        in_valid = 1'b1;
        #1 check({name, ".in_ready"}, 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        op1      = 8'($urandom);
        op2      = 8'($urandom);
        opcode   = 4'($urandom);
        lat      = 1;
        while (!out_valid && lat < 40) begin
            check({name, ".busy_in_ready"}, 32'(in_ready), 32'd0);
            @(negedge clk);
            lat++;
        end
        check({name, ".latency"}, 32'(lat), (opc == 4'h8) ? 32'd9 : 32'd1);
    endtask

    vec_t    vecs[$];
    result_t exp_r;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op1       = '0;
        op2       = '0;
        opcode    = '0;

        vecs.push_back('{"add_ff_01",  4'h4, 8'hFF, 8'h01, '{8'h00, 1'b1, 1'b0, 12'h000}});
        vecs.push_back('{"sub_ff_01",  4'h5, 8'hFF, 8'h01, '{8'hFE, 1'b1, 1'b0, 12'h000}});
        vecs.push_back('{"subn_ff_01", 4'h7, 8'hFF, 8'h01, '{8'h02, 1'b0, 1'b0, 12'h000}});
        vecs.push_back('{"shr_ff",     4'h6, 8'hFF, 8'h00, '{8'h7F, 1'b1, 1'b0, 12'h000}});
        vecs.push_back('{"shl_ff",     4'hE, 8'hFF, 8'h00, '{8'hFE, 1'b1, 1'b0, 12'h000}});
        vecs.push_back('{"bcd_ff",     4'h8, 8'hFF, 8'h00, '{8'hFF, 1'b0, 1'b0, 12'h255}});
        vecs.push_back('{"bcd_00",     4'h8, 8'h00, 8'h00, '{8'h00, 1'b0, 1'b0, 12'h000}});
        vecs.push_back('{"undef_f",    4'hF, 8'hAA, 8'h55, '{8'h00, 1'b0, 1'b1, 12'h000}});
        vecs.push_back('{"ld_5a",      4'h0, 8'h11, 8'h5A, '{8'h5A, 1'b0, 1'b0, 12'h000}});
        vecs.push_back('{"or_3c_81",   4'h1, 8'h3C, 8'h81, '{8'hBD, 1'b0, 1'b0, 12'h000}});
        vecs.push_back('{"and_f0_3c",  4'h2, 8'hF0, 8'h3C, '{8'h30, 1'b0, 1'b0, 12'h000}});
        vecs.push_back('{"sub_01_02",  4'h5, 8'h01, 8'h02, '{8'hFF, 1'b0, 1'b0, 12'h000}});
        vecs.push_back('{"add_80_80",  4'h4, 8'h80, 8'h80, '{8'h00, 1'b1, 1'b0, 12'h000}});
        vecs.push_back('{"bcd_9f",     4'h8, 8'h9F, 8'h00, '{8'h9F, 1'b0, 1'b0, 12'h159}});
        vecs.push_back('{"undef_9",    4'h9, 8'h12, 8'h34, '{8'h00, 1'b0, 1'b1, 12'h000}});
        vecs.push_back('{"shl_40",     4'hE, 8'h40, 8'h00, '{8'h80, 1'b0, 1'b0, 12'h000}});
        vecs.push_back('{"shr_02",     4'h6, 8'h02, 8'h00, '{8'h01, 1'b0, 1'b0, 12'h000}});
        vecs.push_back('{"subn_33_33", 4'h7, 8'h33, 8'h33, '{8'h00, 1'b1, 1'b0, 12'h000}});

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_zero("reset");

        // Directed table, issued back to back with out_ready held high.
        foreach (vecs[i]) begin
            send(vecs[i].name, vecs[i].opc, vecs[i].a, vecs[i].b);
            check_result(vecs[i].name, vecs[i].exp);
        end
        @(negedge clk);
        check("idle_after_table.out_valid", 32'(out_valid), 32'd0);

        // Consumer stall on an OR result while an XOR waits at the input.
        send("stall_or", 4'h1, 8'h3C, 8'h81);
        out_ready = 1'b0;
        opcode    = 4'h3;
        op1       = 8'hF0;
        op2       = 8'h0F;
        in_valid  = 1'b1;
        exp_r     = model(4'h1, 32'h3C, 32'h81);
        repeat (5) begin
            @(negedge clk);
            check_result("stall_or.hold", exp_r);
            check("stall_or.in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check_result("b2b_xor", model(4'h3, 32'hF0, 32'h0F));
        @(negedge clk);
        check("b2b_xor.drop.out_valid", 32'(out_valid), 32'd0);

        // Randomized operations with occasional stalls and idle gaps.
        for (int i = 0; i < 80; i++) begin
            logic [3:0] r_opc;
            logic [7:0] r_a;
            logic [7:0] r_b;
            r_opc = 4'($urandom_range(0, 15));
            r_a   = 8'($urandom);
            r_b   = 8'($urandom);
            exp_r = model(r_opc, 32'(r_a), 32'(r_b));
            send("rand", r_opc, r_a, r_b);
            check_result("rand", exp_r);
            if ($urandom_range(0, 3) == 0) begin
                out_ready = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    @(negedge clk);
                    check_result("rand.stall", exp_r);
                    check("rand.stall.in_ready", 32'(in_ready), 32'd0);
                end
                out_ready = 1'b1;
            end
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                check("rand.gap.out_valid", 32'(out_valid), 32'd0);
            end
        end
        @(negedge clk);

        // Reset on the fourth cycle of a BCD run aborts it silently.
        opcode   = 4'h8;
        op1      = 8'hFF;
        op2      = 8'h00;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero("rst_mid_bcd");
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("rst_mid_bcd.no_pulse", 32'(out_valid), 32'd0);
        end

        // An accept presented together with reset is ignored.
        rst      = 1'b1;
        opcode   = 4'h0;
        op2      = 8'h5A;
        in_valid = 1'b1;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        check_zero("rst_with_accept");
        @(negedge clk);
        check("rst_with_accept.later.out_valid", 32'(out_valid), 32'd0);
        check("rst_with_accept.later.out", 32'(out), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
